// File: rtl/i2c_poll_ctrl.sv
// i2c_poll_ctrl: sequences poll transactions to an I2C peripheral and shares its bus with the CPU.
// Ports: clk, rst_n, CPU rib (we_i/addr_i/data_i/data_o), peripheral bus (i2c_*), busy_o. Macro I2C_POLL_TIMER_EN adds a periodic tick.
module i2c_poll_ctrl #(
  parameter int         WAIT_CYCLES = 16000,
  parameter logic [7:0] DEV_ADDR    = 8'h91
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        i2c_we_o,
  output logic [31:0] i2c_addr_o,
  output logic [31:0] i2c_data_o,
  input  logic [31:0] i2c_data_i,
  output logic        busy_o
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WLAST = CW'(WAIT_CYCLES - 1);

  localparam logic [31:0] A_DEV = 32'h0001_0000;
  localparam logic [31:0] A_RD  = 32'h0003_0000;
  localparam logic [31:0] A_EN  = 32'h0004_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_EN,
    S_WR_DIS,
    S_WAIT,
    S_RD
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          ctrl_en;
  logic          pend;
  logic          coll;
  logic          res_val;
  logic [15:0]   res_data;

  logic [3:0]  dec;
  logic        sel_i2c;
  logic        sel_ctrl;
  logic        sel_per;
  logic        sel_res;
  logic        sel_stat;
  logic        busy;
  logic        oneshot;
  logic        tick;
  logic        trig;
  logic        rd_res;
  logic [31:0] per_rd;
  logic [31:0] rd_mux;

  assign dec      = addr_i[19:16];
  assign sel_i2c  = (dec >= 4'h1) && (dec <= 4'h4);
  assign sel_ctrl = (dec == 4'h8);
  assign sel_per  = (dec == 4'h9);
  assign sel_res  = (dec == 4'hA);
  assign sel_stat = (dec == 4'hB);

  assign busy    = (state != S_IDLE);
  assign busy_o  = busy;
  assign oneshot = we_i && sel_ctrl && data_i[1];
  assign trig    = oneshot || tick;
  assign rd_res  = !we_i && sel_res;

`ifdef I2C_POLL_TIMER_EN
  logic [31:0] period_q;
  logic [31:0] tcnt;

  // tcnt sits at 0 while disabled, so enabling restarts the period.
  assign tick   = ctrl_en && (period_q != 32'd0)
                  && (tcnt >= period_q - 32'd1);
  assign per_rd = period_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= 32'd100000;
      tcnt     <= 32'd0;
    end else begin
      if (we_i && sel_per)
        period_q <= data_i;
      if (!ctrl_en || tick)
        tcnt <= 32'd0;
      else
        tcnt <= tcnt + 32'd1;
    end
  end
`else
  assign tick   = 1'b0;
  assign per_rd = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      ctrl_en  <= 1'b0;
      pend     <= 1'b0;
      coll     <= 1'b0;
      res_val  <= 1'b0;
      res_data <= 16'd0;
    end else begin
      if (we_i && sel_ctrl)
        ctrl_en <= data_i[0];
      if (we_i && sel_i2c && busy)
        coll <= 1'b1;
      else if (we_i && sel_stat && data_i[1])
        coll <= 1'b0;
      if (rd_res)
        res_val <= 1'b0;
      if (busy && trig)
        pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (trig || pend) begin
            state <= S_WR_ADDR;
            pend  <= 1'b0;
          end
        end
        S_WR_ADDR: state <= S_WR_EN;
        S_WR_EN:   state <= S_WR_DIS;
        S_WR_DIS: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WLAST)
            state <= S_RD;
          else
            wcnt <= wcnt + 1'b1;
        end
        // A new result beats a coincident CPU read clearing valid.
        S_RD: begin
          res_data <= i2c_data_i[15:0];
          res_val  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    i2c_we_o   = we_i;
    i2c_addr_o = addr_i;
    i2c_data_o = data_i;
    unique case (state)
      S_IDLE: begin
      end
      S_WR_ADDR: begin
        i2c_we_o   = 1'b1;
        i2c_addr_o = A_DEV;
        i2c_data_o = {24'd0, DEV_ADDR};
      end
      S_WR_EN: begin
        i2c_we_o   = 1'b1;
        i2c_addr_o = A_EN;
        i2c_data_o = 32'd1;
      end
      S_WR_DIS: begin
        i2c_we_o   = 1'b1;
        i2c_addr_o = A_EN;
        i2c_data_o = 32'd0;
      end
      S_WAIT: begin
        i2c_we_o   = 1'b0;
        i2c_addr_o = 32'd0;
        i2c_data_o = 32'd0;
      end
      S_RD: begin
        i2c_we_o   = 1'b0;
        i2c_addr_o = A_RD;
        i2c_data_o = 32'd0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    unique case (1'b1)
      sel_i2c:  rd_mux = busy ? 32'd0 : i2c_data_i;
      sel_ctrl: rd_mux = {31'd0, ctrl_en};
      sel_per:  rd_mux = per_rd;
      sel_res:  rd_mux = {15'd0, res_val, res_data};
      sel_stat: rd_mux = {30'd0, coll, busy};
      default:  rd_mux = 32'd0;
    endcase
  end

  assign data_o = rst_n ? rd_mux : 32'd0;

endmodule
